fifo_access_ctrl: RTL and testbench
===================================

Name: fifo_access_ctrl

Overview:
- Write arbiter and read scheduler in front of FIFO_wrapper.
- Shares the FIFO's single write port between two producers (round-robin) and serves one consumer.
- FIFO_wrapper exposes no full/empty flags, so this block keeps the occupancy count and blocks overflow and underflow.
- Sits between the Arty7 top-level producers/consumer and the FIFO_wrapper instance.

Parameters:
DATA_W, `BIT_DEPTH, word width; must match FIFO_wrapper
FIFO_DEPTH, 16, number of FIFO entries; power of two, >=2
CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived; not overridden)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  producer 0 write request; held until gnt0
data0  in  DATA_W  producer 0 write data; stable while req0=1
gnt0  out  1  one-cycle grant; data0 captured on that edge
req1  in  1  producer 1 write request
data1  in  DATA_W  producer 1 write data
gnt1  out  1  one-cycle grant to producer 1
rd_req  in  1  consumer read request; level, one word per accepted cycle
rd_gnt  out  1  one-cycle pulse; read accepted
rd_valid  out  1  one-cycle pulse; rd_data holds a popped word
rd_data  out  DATA_W  popped word, registered
fifo_enable_write  out  1  to FIFO_wrapper enable_write
fifo_value_to_write  out  DATA_W  to FIFO_wrapper value_to_write
fifo_enable_read  out  1  to FIFO_wrapper enable_read
fifo_value_to_read  in  DATA_W  from FIFO_wrapper value_to_read
count  out  CNT_W  current occupancy, 0..FIFO_DEPTH
full  out  1  count==FIFO_DEPTH
empty  out  1  count==0

Behaviour:
- Reset (rst=1 at a clk edge): all pulses 0 (gnt0, gnt1, rd_gnt, rd_valid, fifo_enable_write, fifo_enable_read); count=0; empty=1; full=0; rd_data=0; fifo_value_to_write=0; last_grant=1, so producer 0 wins the first tie.
- Reset mid-operation: in-flight grants and reads are dropped. count returns to 0. The FIFO_wrapper shares rst and clears in step.
- Write arbitration is evaluated each cycle from registered state.
  - Condition: write_ok = !full.
  - One requester and write_ok: grant it.
  - Both requesters and write_ok: grant the one that is not last_grant, then update last_grant.
  - Outputs are registered, so gnt, fifo_enable_write and fifo_value_to_write assert on the edge after req is sampled. Latency is 1 cycle.
  - A continuously held req with no competitor is granted every cycle.
  - With two continuous requesters, grants alternate 0,1,0,1.
  - When full=1, no grant is issued. Requests stay pending without loss.
- Read scheduling:
  - If rd_req and !empty, pulse rd_gnt and fifo_enable_read on the next edge.
  - FIFO_wrapper presents data one cycle after enable_read. rd_data is captured from fifo_value_to_read with rd_valid one cycle after fifo_enable_read, i.e. 2 cycles after rd_req is sampled.
  - When empty=1, rd_req is ignored: no rd_gnt, no FIFO read.
- Occupancy: count_next = count + wr_issue - rd_issue.
  - Simultaneous write and read leaves count unchanged.
  - Full and empty are decided from the current count only; a write is never admitted at full on the strength of a same-cycle read.
  - count never exceeds FIFO_DEPTH and never wraps below 0. Checked by assertions in simulation.
- full and empty are registered and consistent with count every cycle.
- Internal state: a 1-bit last_grant pointer plus the counter. No multi-state FSM on the write side. The read side is a 2-stage valid pipeline (issue -> capture).

Decomposition:
- Shared header, alongside the existing `BIT_DEPTH define: FIFO_DEPTH default and the derived counter width macro.
- One natural sub-module: rr_arb2. It is the 2-way round-robin arbiter holding last_grant and producing a one-hot grant. fifo_access_ctrl instantiates it, the occupancy counter, and the read pipeline.

Test Plan:
- Reset then idle: hold rst 2 cycles -> count=0, empty=1, full=0, all pulses 0; rd_req=1 while empty -> no rd_gnt, no fifo_enable_read.
- Single producer: req0=1, data0=0xA5 for 1 cycle -> next cycle gnt0=1, fifo_enable_write=1, fifo_value_to_write=0xA5, count=1, empty=0.
- Contention: req0 and req1 held for 4 cycles, data0=0x11, data1=0x22 -> grants 0,1,0,1; FIFO receives 11,22,11,22; count=4.
- Fill to full: FIFO_DEPTH=16, req0 held 20 cycles -> exactly 16 gnt0 pulses, full=1, count=16, remaining request stalls; one rd_req -> full drops, gnt0 resumes next cycle.
- Order and latency: write 0x01,0x02,0x03, then rd_req held 3 cycles -> rd_valid 2 cycles after each accepted rd_req, rd_data=01,02,03, empty=1 at end.
- Simultaneous push and pop at count=5 with req1 and rd_req held 8 cycles -> count stays 5 throughout, data order preserved. Assert rst mid-burst -> count=0 next cycle, no rd_valid from dropped reads.

Source files
------------

// File: rtl/fifo_access_ctrl_pkg.sv
// fifo_access_ctrl_pkg: shared widths, depth and arbiter types for the FIFO access controller
package fifo_access_ctrl_pkg;
    localparam int BIT_DEPTH = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    typedef enum logic {GRANT_P0 = 1'b0, GRANT_P1 = 1'b1} grant_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_access_ctrl_if.sv
// fifo_access_ctrl_if: producer, consumer and FIFO_wrapper signals of the access controller
interface fifo_access_ctrl_if
    import fifo_access_ctrl_pkg::*;
#(
    parameter int DATA_W = BIT_DEPTH,
    parameter int CNT_W = cnt_w(FIFO_DEPTH_DEF)
);
    logic req0, gnt0, req1, gnt1;
    logic [DATA_W-1:0] data0, data1;
    logic rd_req, rd_gnt, rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic fifo_enable_write, fifo_enable_read;
    logic [DATA_W-1:0] fifo_value_to_write, fifo_value_to_read;
    logic [CNT_W-1:0] count;
    logic full, empty;
    modport master (
        output req0, data0, req1, data1, rd_req, fifo_value_to_read,
        input gnt0, gnt1, rd_gnt, rd_valid, rd_data, fifo_enable_write, fifo_enable_read,
        input fifo_value_to_write, count, full, empty
    );
    modport slave (
        input req0, data0, req1, data1, rd_req, fifo_value_to_read,
        output gnt0, gnt1, rd_gnt, rd_valid, rd_data, fifo_enable_write, fifo_enable_read,
        output fifo_value_to_write, count, full, empty
    );
endinterface

// File: rtl/fifo_access_ctrl_rr_arb2.sv
// fifo_access_ctrl_rr_arb2: 2-way round-robin arbiter, one-hot grant, pointer moves only on contention
module fifo_access_ctrl_rr_arb2
    import fifo_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    grant_t last_grant;
    always_comb begin
        gnt = !en ? 2'b00 : (&req) ? ((last_grant == GRANT_P1) ? 2'b01 : 2'b10) : req;
    end
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= GRANT_P1;
        else if (en && &req)
            last_grant <= (last_grant == GRANT_P1) ? GRANT_P0 : GRANT_P1;
    end
endmodule

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: shares FIFO_wrapper's write port between two producers and schedules consumer reads,
// tracking occupancy since the wrapper has no full/empty flags
module fifo_access_ctrl
    import fifo_access_ctrl_pkg::*;
#(
    parameter int DATA_W = BIT_DEPTH,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input logic clk,
    input logic rst,
    fifo_access_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    logic [1:0] gnt_c;
    logic wr_issue, rd_issue;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0] cnt_next;
    fifo_access_ctrl_rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .req({bus.req1, bus.req0}),
        .en(!bus.full),
        .gnt(gnt_c)
    );
    // full/empty come from the registered count, so a same-cycle read never frees a slot early
    always_comb begin
        wr_issue = |gnt_c;
        rd_issue = bus.rd_req && !bus.empty;
        wr_data = gnt_c[1] ? bus.data1 : bus.data0;
        cnt_next = bus.count + CNT_W'(wr_issue) - CNT_W'(rd_issue);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.fifo_enable_write <= 1'b0;
            bus.fifo_value_to_write <= '0;
            bus.rd_gnt <= 1'b0;
            bus.fifo_enable_read <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data <= '0;
            bus.count <= '0;
            bus.full <= 1'b0;
            bus.empty <= 1'b1;
        end else begin
            bus.gnt0 <= gnt_c[0];
            bus.gnt1 <= gnt_c[1];
            bus.fifo_enable_write <= wr_issue;
            if (wr_issue)
                bus.fifo_value_to_write <= wr_data;
            bus.rd_gnt <= rd_issue;
            bus.fifo_enable_read <= rd_issue;
            bus.rd_valid <= bus.fifo_enable_read;
            if (bus.fifo_enable_read)
                bus.rd_data <= bus.fifo_value_to_read;
            bus.count <= cnt_next;
            bus.full <= cnt_next == CNT_W'(FIFO_DEPTH);
            bus.empty <= cnt_next == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (bus.count <= CNT_W'(FIFO_DEPTH));
            assert (bus.empty == (bus.count == '0));
            assert (bus.full == (bus.count == CNT_W'(FIFO_DEPTH)));
        end
    end
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb_fifo_access_ctrl: directed checks of arbitration, occupancy limits and read latency
module tb_fifo_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    fifo_access_ctrl_if bus ();
    fifo_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // behavioural FIFO_wrapper: word at the read pointer is visible until enable_read advances it
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    always @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (bus.fifo_enable_write) begin
                mem[wp] <= bus.fifo_value_to_write;
                wp <= wp + 4'd1;
            end
            if (bus.fifo_enable_read)
                rp <= rp + 4'd1;
        end
    end
    assign bus.fifo_value_to_read = mem[rp];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [8];
        int g;
        seq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC0, 8'hC1, 8'hC2};
        bus.data0 = '0;
        bus.data1 = '0;
        do_reset();
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_pulses", {bus.gnt0, bus.gnt1, bus.rd_gnt, bus.rd_valid, bus.fifo_enable_write, bus.fifo_enable_read}, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_wr_value", bus.fifo_value_to_write, 0);
        bus.rd_req = 1'b1;
        tick();
        chk("empty_rd_gnt", bus.rd_gnt, 0);
        chk("empty_fifo_rd", bus.fifo_enable_read, 0);
        tick();
        chk("empty_rd_valid", bus.rd_valid, 0);
        bus.rd_req = 1'b0;

        bus.req0 = 1'b1;
        bus.data0 = 8'hA5;
        tick();
        bus.req0 = 1'b0;
        chk("single_gnt0", bus.gnt0, 1);
        chk("single_wen", bus.fifo_enable_write, 1);
        chk("single_value", bus.fifo_value_to_write, 8'hA5);
        chk("single_count", bus.count, 1);
        chk("single_empty", bus.empty, 0);
        tick();
        chk("single_gnt0_drop", bus.gnt0, 0);

        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt0", bus.gnt0, (i % 2 == 0) ? 1 : 0);
            chk("rr_gnt1", bus.gnt1, (i % 2 == 1) ? 1 : 0);
            chk("rr_value", bus.fifo_value_to_write, (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("rr_count", bus.count, 4);

        do_reset();
        bus.req0 = 1'b1;
        bus.data0 = 8'h55;
        g = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.gnt0) g++;
        end
        chk("fill_grants", g, 16);
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, 16);
        chk("fill_stall", bus.gnt0, 0);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk("fill_rd_gnt", bus.rd_gnt, 1);
        chk("fill_no_gnt_at_full", bus.gnt0, 0);
        chk("fill_full_drop", bus.full, 0);
        chk("fill_count15", bus.count, 15);
        tick();
        chk("fill_resume", bus.gnt0, 1);
        chk("fill_refull", bus.full, 1);
        chk("fill_rd_valid", bus.rd_valid, 1);
        chk("fill_rd_data", bus.rd_data, 8'h55);
        bus.req0 = 1'b0;

        do_reset();
        bus.req0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.data0 = 8'(i);
            tick();
        end
        bus.req0 = 1'b0;
        chk("ord_count", bus.count, 3);
        bus.rd_req = 1'b1;
        tick();
        chk("ord_rd_gnt1", bus.rd_gnt, 1);
        chk("ord_no_valid_yet", bus.rd_valid, 0);
        tick();
        chk("ord_valid1", bus.rd_valid, 1);
        chk("ord_data1", bus.rd_data, 8'h01);
        tick();
        chk("ord_valid2", bus.rd_valid, 1);
        chk("ord_data2", bus.rd_data, 8'h02);
        chk("ord_empty", bus.empty, 1);
        bus.rd_req = 1'b0;
        tick();
        chk("ord_rd_gnt_off", bus.rd_gnt, 0);
        chk("ord_valid3", bus.rd_valid, 1);
        chk("ord_data3", bus.rd_data, 8'h03);
        tick();
        chk("ord_valid_off", bus.rd_valid, 0);

        do_reset();
        bus.req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.data1 = 8'hB0 + 8'(i);
            tick();
            chk("pp_pre_gnt1", bus.gnt1, 1);
        end
        chk("pp_count5", bus.count, 5);
        bus.rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.data1 = 8'hC0 + 8'(i);
            tick();
            chk("pp_count", bus.count, 5);
            chk("pp_gnt1", bus.gnt1, 1);
            if (i > 0) chk("pp_rd_data", bus.rd_data, 32'(seq[i - 1]));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req1 = 1'b0;
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_empty", bus.empty, 1);
        chk("mid_rst_valid", bus.rd_valid, 0);
        chk("mid_rst_gnt", {bus.gnt1, bus.rd_gnt}, 0);
        tick();
        chk("mid_rst_dropped", bus.rd_valid, 0);
        chk("mid_rst_rd_gnt", bus.rd_gnt, 0);
        bus.rd_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
